c_credit_tracker: RTL
=====================

// Module: c_credit_tracker
// PURPOSE
//  Per-VC output credit tracker for the buffered router output port.
//  Holds one wrap-free credit counter per downstream VC: a flit sent debits a credit,
//  a credit returned from downstream restores one.
//  Drives credit_avail to the VC/switch allocators, which consume it.
//  Drives all_free to VC reallocation logic, which consumes it.
//  Flags protocol violations: underflow and overflow.
// PARAMETERS
//  num_vcs      2        number of downstream VCs tracked
//  num_credits  4        buffer depth per downstream VC (>=1); reset count value
//  cnt_width    derived  clogb(num_credits+1); not overridable
// PORTS
//  clk            input   1        clock
//  reset          input   1        async, active-high reset
//  debit_vc       input   num_vcs  one-hot; VC of flit leaving this cycle (all-zero = none)
//  credit_vc      input   num_vcs  one-hot; VC of credit returned this cycle (all-zero = none)
//  credit_avail   output  num_vcs  count[v] != 0
//  all_free       output  num_vcs  count[v] == num_credits
//  error_under    output  1        registered: debit seen on a VC with count==0
//  error_over     output  1        registered: credit seen on a VC with count==num_credits
// BEHAVIOUR
//  - Clock and reset: one clock, clk; reset is asynchronous and active-high.
//  - Reset state: every count = num_credits, so credit_avail = all 1s and all_free = all 1s.
//    error_under = error_over = 0.
//  - Per VC v, each rising edge, with d = debit_vc[v] and c = credit_vc[v]:
//    d & ~c -> count - 1
//    c & ~d -> count + 1
//    c & d  -> count unchanged, no error even when count==0 or full
//    else   -> hold
//  - Saturation: a debit at count==0 holds the count at 0 and sets error_under next cycle.
//    A credit at count==num_credits holds the count at num_credits and sets error_over next cycle.
//    Counts never wrap.
//  - Errors are one-cycle pulses registered from the violating cycle; they are not sticky.
//    Either error is the OR of the per-VC violations.
//  - Latency:
//    - credit_avail and all_free are decoded from the count registers only; no input bypass.
//    - A debit or credit in cycle N is visible at the outputs in cycle N+1.
//    - A credit returned in cycle N does not unblock a debit in cycle N.
//  - Input legality: a non-one-hot debit_vc or credit_vc (more than one bit set) is illegal.
//    The RTL still applies each set bit independently; no error is flagged.
//  - Reset mid-operation: every count returns to num_credits immediately (async).
//    Pending error pulses are cleared.
//  - Arithmetic: cnt_width-bit unsigned.
//    - Decrement: same -1 arithmetic as the c_decr wrap decrementer, with min=0 and max=num_credits,
//      but wrap is suppressed by the saturation check above.
//    - Increment: +1 with no wrap.
// STRUCTURE
//  - Width function: clogb comes from the shared c_functions include.
//  - Reset style: the global reset-type selector comes from the shared c_constants include.
//  - Sub-module c_credit_counter: one VC's register plus next-state logic.
//    Ports: clk, reset, debit, credit, nonzero, full, under, over.
//    Instantiated num_vcs times in a generate loop.
//  - The top level ORs under/over into the error registers.
// TESTING  (num_vcs=2, num_credits=4)
//  1 Reset: after reset release -> credit_avail=2'b11, all_free=2'b11, both errors 0.
//  2 Drain VC0: debit_vc=2'b10 for 4 cycles.
//    -> credit_avail[0] drops in the cycle after the 4th debit.
//    -> all_free[0]=0 after the first debit; VC1 unaffected.
//  3 Underflow: VC0 at 0, debit_vc=2'b10 once.
//    -> error_under=1 for exactly the next cycle; count stays 0.
//  4 Simultaneous: VC0 at 0, debit_vc=credit_vc=2'b10.
//    -> count stays 0, no error; credit_avail[0] remains 0.
//  5 Overflow: VC1 full, credit_vc=2'b01.
//    -> error_over=1 for one cycle; all_free[1] stays 1.
//  6 Reset mid-run: VC0=2, VC1=1, assert reset asynchronously mid-cycle.
//    -> outputs go to 2'b11 / 2'b11 before the next edge.
//  - Scoreboard: a model of the counts checks outputs every cycle of a random legal debit/credit stream.

Source files
------------

// File: rtl/c_credit_tracker_pkg.sv
// Shared types and width helpers for the per-VC output credit tracker.
package c_credit_tracker_pkg;

  // Bits needed to encode values 0 .. value-1.
  function automatic int unsigned clogb(input int unsigned value);
    return $clog2(value);
  endfunction

  typedef enum logic [1:0] {
    CntHold,
    CntDecr,
    CntIncr
  } cnt_op_e;

endpackage

// File: rtl/c_credit_counter.sv
// One downstream VC's credit register: saturating debit/credit counter with
// violation detection.
module c_credit_counter
  import c_credit_tracker_pkg::*;
#(
  parameter int unsigned NumCredits = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_debit,
  input  logic i_credit,
  output logic o_nonzero,
  output logic o_full,
  output logic o_under,
  output logic o_over
);

  localparam int unsigned CntWidth = clogb(NumCredits + 1);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(NumCredits);

  logic [CntWidth-1:0] r_count;
  logic [CntWidth-1:0] w_count_next;
  logic                w_at_zero;
  logic                w_at_max;
  cnt_op_e             w_op;

  always_comb begin
    w_at_zero = (r_count == '0);
    w_at_max  = (r_count == CntMax);
    w_op      = CntHold;
    // A simultaneous debit and credit cancel, so neither saturation case applies.
    if (i_debit && !i_credit && !w_at_zero) begin
      w_op = CntDecr;
    end else if (i_credit && !i_debit && !w_at_max) begin
      w_op = CntIncr;
    end
    case (w_op)
      CntDecr: w_count_next = r_count - CntWidth'(1);
      CntIncr: w_count_next = r_count + CntWidth'(1);
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_count <= CntMax;
    end else begin
      r_count <= w_count_next;
    end
  end

  assign o_nonzero = !w_at_zero;
  assign o_full    = w_at_max;
  assign o_under   = i_debit && !i_credit && w_at_zero;
  assign o_over    = i_credit && !i_debit && w_at_max;

endmodule

// File: rtl/c_credit_tracker.sv
// Per-VC output credit tracker: one saturating counter per downstream VC plus
// registered underflow/overflow pulses. VC 0 is the leftmost bit of each vector.
module c_credit_tracker
  import c_credit_tracker_pkg::*;
#(
  parameter int unsigned NumVcs     = 2,
  parameter int unsigned NumCredits = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [0:NumVcs-1] i_debit_vc,
  input  logic [0:NumVcs-1] i_credit_vc,
  output logic [0:NumVcs-1] o_credit_avail,
  output logic [0:NumVcs-1] o_all_free,
  output logic              o_error_under,
  output logic              o_error_over
);

  logic [0:NumVcs-1] w_under;
  logic [0:NumVcs-1] w_over;
  logic              r_error_under;
  logic              r_error_over;

  for (genvar v = 0; v < NumVcs; v++) begin : g_vc
    c_credit_counter #(
      .NumCredits(NumCredits)
    ) u_counter (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_debit  (i_debit_vc[v]),
      .i_credit (i_credit_vc[v]),
      .o_nonzero(o_credit_avail[v]),
      .o_full   (o_all_free[v]),
      .o_under  (w_under[v]),
      .o_over   (w_over[v])
    );
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_error_under <= 1'b0;
      r_error_over  <= 1'b0;
    end else begin
      r_error_under <= |w_under;
      r_error_over  <= |w_over;
    end
  end

  assign o_error_under = r_error_under;
  assign o_error_over  = r_error_over;

endmodule
